// File: rtl/hub_slot_arb.sv
// hub_slot_arb: round-robin hub memory access sequencer for eight cogs.
// Define HUB_SKIP_IDLE_EN to grant the first eligible cog from hub_slot instead of fixed rotation.
module hub_slot_arb (
   input  logic         clk_cog,
   input  logic         nres,
   input  logic         ena_bus,
   input  logic [7:0]   cog_req,
   input  logic [7:0]   cog_w,
   input  logic [15:0]  cog_sz,
   input  logic [127:0] cog_a,
   input  logic [255:0] cog_d,
   output logic [7:0]   cog_ack,
   output logic [31:0]  cog_q,
   output logic [2:0]   hub_slot,
   output logic         mem_w,
   output logic [3:0]   mem_wb,
   output logic [13:0]  mem_a,
   output logic [31:0]  mem_d,
   input  logic [31:0]  mem_q
);
   logic [7:0]  busy, elig;
   logic        gnt, gw, is_b, is_w, v1, v2;
   logic [2:0]  gid, nxt_slot, id1, id2;
   logic [1:0]  gsz, sz1, sz2, lo1, lo2;
   logic [15:0] ga;
   logic [31:0] gd, wd, fq;
   logic [3:0]  wb;
   // a cog with a request in either pipeline stage may not be granted again
   assign busy = ({8{v1}} & (8'b1 << id1)) | ({8{v2}} & (8'b1 << id2));
   assign elig = cog_req & ~busy;
`ifdef HUB_SKIP_IDLE_EN
   always_comb begin
      gnt = 1'b0;
      gid = hub_slot;
      for (int i = 7; i >= 0; i--)
         if (elig[hub_slot + 3'(i)]) begin
            gnt = 1'b1;
            gid = hub_slot + 3'(i);
         end
   end
   assign nxt_slot = gnt ? gid + 3'd1 : hub_slot + 3'd1;
`else
   assign gnt      = elig[hub_slot];
   assign gid      = hub_slot;
   assign nxt_slot = hub_slot + 3'd1;
`endif
   assign gw   = cog_w[gid];
   assign gsz  = cog_sz[{gid, 1'b0} +: 2];
   assign ga   = cog_a[{gid, 4'b0000} +: 16];
   assign gd   = cog_d[{gid, 5'b00000} +: 32];
   assign is_b = gsz == 2'b00;
   assign is_w = gsz == 2'b01;
   assign wd   = is_b ? {4{gd[7:0]}} : is_w ? {2{gd[15:0]}} : gd;
   assign wb   = is_b ? 4'b0001 << ga[1:0] : is_w ? (ga[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign fq   = sz2 == 2'b00 ? {24'd0, mem_q[{lo2, 3'b000} +: 8]} :
                 sz2 == 2'b01 ? {16'd0, lo2[1] ? mem_q[31:16] : mem_q[15:0]} : mem_q;
   always_ff @(posedge clk_cog or negedge nres)
      if (!nres) begin
         hub_slot <= '0;
         cog_ack  <= '0;
         cog_q    <= '0;
         mem_w    <= 1'b0;
         mem_wb   <= '0;
         mem_a    <= '0;
         mem_d    <= '0;
         v1       <= 1'b0;
         v2       <= 1'b0;
         id1      <= '0;
         id2      <= '0;
         sz1      <= '0;
         sz2      <= '0;
         lo1      <= '0;
         lo2      <= '0;
      end else begin
         cog_ack <= (ena_bus && v2) ? 8'b1 << id2 : 8'b0;
         if (ena_bus) begin
            hub_slot <= nxt_slot;
            v1       <= gnt;
            id1      <= gid;
            sz1      <= gsz;
            lo1      <= ga[1:0];
            v2       <= v1;
            id2      <= id1;
            sz2      <= sz1;
            lo2      <= lo1;
            mem_w    <= gnt & gw;
            mem_wb   <= (gnt & gw) ? wb : 4'b0000;
            if (v2) cog_q <= fq;
            if (gnt) begin
               mem_a <= ga[15:2];
               mem_d <= wd;
            end
         end
      end
endmodule
